// File: rtl/pipe_output_fifo_if.sv
// ============================================================================
// pipe_output_fifo_if : pipeline-side and consumer-side stream signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_output_fifo_if #(
   parameter int DATA_W = 8
);
   logic              src_valid;
   logic [DATA_W-1:0] pipe_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   // master: upstream source plus downstream consumer (bench side)
   modport master (
      output src_valid,
      output pipe_data,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   // slave: the capture FIFO
   modport slave (
      input  src_valid,
      input  pipe_data,
      input  out_ready,
      output out_data,
      output out_valid
   );
endinterface

`default_nettype wire

// File: rtl/pipe_output_fifo.sv
// ============================================================================
// pipe_output_fifo : valid-tag shift register + show-ahead FIFO behind the
// fixed-latency pipeline. Optional macro OVF_COUNT_EN adds drop_count.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_output_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int PIPE_LAT = 5
) (
   input  wire logic                   clk,
   input  wire logic                   reset_n,
   input  wire logic                   flush,
   pipe_output_fifo_if.slave           bus,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        full,
   output logic                        empty,
   output logic                        overflow
`ifdef OVF_COUNT_EN
   ,
   output logic [7:0]                  drop_count
`endif
);

   localparam int c_ADDR_W = $clog2(DEPTH);
   localparam int c_CNT_W  = c_ADDR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

   logic [PIPE_LAT-1:0] r_tags;
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic                r_overflow;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic w_push;
   logic w_pop;
   logic w_write;
   logic w_drop;

   // Tag pipe mirrors the pipeline latency so a tag reaches the tail exactly
   // when its byte is stable on pipe_data.
   generate
      if (PIPE_LAT == 1) begin : g_tag_single
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)   r_tags <= '0;
            else if (flush) r_tags <= '0;
            else            r_tags <= bus.src_valid;
         end
      end else begin : g_tag_shift
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)   r_tags <= '0;
            else if (flush) r_tags <= '0;
            else            r_tags <= {r_tags[PIPE_LAT-2:0], bus.src_valid};
         end
      end
   endgenerate

   assign w_push  = r_tags[PIPE_LAT-1] & ~flush;
   assign w_pop   = bus.out_valid & bus.out_ready & ~flush;
   // A full FIFO still accepts the push when the head leaves the same edge.
   assign w_write = w_push & (~full | w_pop);
   assign w_drop  = w_push & full & ~w_pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_write && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_write) r_count <= r_count - 1'b1;
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_write) r_mem[r_wr_ptr] <= bus.pipe_data;
   end

`ifdef OVF_COUNT_EN
   logic [7:0] r_drop_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          r_drop_count <= '0;
      else if (flush)                        r_drop_count <= '0;
      else if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
   end

   assign drop_count = r_drop_count;
`endif

   assign count         = r_count;
   assign full          = (r_count == c_DEPTH_CNT);
   assign empty         = (r_count == '0);
   assign overflow      = r_overflow;
   assign bus.out_valid = ~empty;
   // Storage is unreset, so mask the head while nothing valid is held.
   assign bus.out_data  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_pipe_output_fifo.sv
// ============================================================================
// tb_pipe_output_fifo : directed + random stimulus against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_output_fifo;
   localparam int DATA_W   = 8;
   localparam int DEPTH    = 8;
   localparam int PIPE_LAT = 5;

   logic       clk;
   logic       reset_n;
   logic       flush;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
`ifdef OVF_COUNT_EN
   logic [7:0] drop_count;
`endif

   pipe_output_fifo_if #(.DATA_W(DATA_W)) bus ();

   pipe_output_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .bus        (bus),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow)
`ifdef OVF_COUNT_EN
      ,
      .drop_count (drop_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: bytes stored, plus source samples still travelling down the pipe
   logic [7:0] exp_q[$];
   int         infl_edge[$];
   logic [7:0] infl_val[$];
   bit         m_ovf;
   int         m_drops;
   int         edge_no;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      infl_edge.delete();
      infl_val.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
   endtask

   task automatic check_all();
      chk("count",     32'(count),         32'(exp_q.size()));
      chk("empty",     32'(empty),         32'(exp_q.size() == 0));
      chk("full",      32'(full),          32'(exp_q.size() == DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("out_data",  32'(bus.out_data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      chk("overflow",  32'(overflow),      32'(m_ovf));
`ifdef OVF_COUNT_EN
      chk("drop_count", 32'(drop_count),   32'(m_drops));
`endif
   endtask

   // One clock edge: drive inputs, emulate the pipeline's data_out, update model.
   task automatic cyc(input bit sv, input logic [7:0] val, input bit rdy, input bit fl);
      logic [7:0] pd;
      bit         mature;
      mature = (infl_edge.size() != 0) && (infl_edge[0] == edge_no + 1 - PIPE_LAT);
      pd     = mature ? infl_val[0] : 8'($urandom);
      bus.src_valid = sv;
      bus.pipe_data = pd;
      bus.out_ready = rdy;
      flush         = fl;
      @(posedge clk);
      edge_no++;
      if (fl) begin
         model_clear();
      end else begin
         if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
         if (mature) begin
            void'(infl_edge.pop_front());
            void'(infl_val.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(pd);
            else begin
               m_ovf = 1'b1;
               if (m_drops < 255) m_drops++;
            end
         end
         if (sv) begin
            infl_edge.push_back(edge_no);
            infl_val.push_back(val);
         end
      end
      #1;
      check_all();
   endtask

   initial begin
      int sent;
      edge_no       = 0;
      model_clear();
      reset_n       = 1'b0;
      flush         = 1'b0;
      bus.src_valid = 1'b0;
      bus.pipe_data = '0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;

      // Asynchronous reset in the middle of traffic
      for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Single byte, latency and pop
      cyc(1'b1, 8'hA0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("single_not_yet", 32'(bus.out_valid), 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("single_data", 32'(bus.out_data), 32'hA0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("single_empty", 32'(empty), 32'd1);

      // Overflow: ten bytes into eight entries
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_flag", 32'(overflow), 32'd1);
`ifdef OVF_COUNT_EN
      chk("ovf_drops", 32'(drop_count), 32'd2);
`endif
      for (int i = 0; i < 8; i++) begin
         chk("drain_order", 32'(bus.out_data), 32'(8'h10 + i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Flush with three tags in flight and four entries stored
      for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pre_flush_count", 32'(count), 32'd4);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_flush_count", 32'(count), 32'd0);

      // Full pass-through: fill, then push and pop every edge for 20 edges
      for (int k = 0; k < 40; k++) cyc(k < 28, 8'(8'h80 + k), k >= 13, 1'b0);
      chk("pass_ovf", 32'(overflow), 32'd0);

      // Wrap-around with random backpressure and random source gaps
      sent = 0;
      for (int i = 0; i < 1000 && sent < 3 * DEPTH; i++) begin
         bit sv;
         sv = 1'($urandom_range(0, 1));
         cyc(sv, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         if (sv) sent++;
      end
      for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_drained", 32'(empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
